// File: rtl/opl3_timers.sv
// rtl/opl3_timers.sv - OPL3 interval timers with IRQ/status generation
//
// Two 8-bit up-counting timers, each advanced by its own prescaler. A timer
// that counts past 0xFF reloads from its preset and raises its flag unless
// masked. The flags drive the status byte and the active-low IRQ line.
//
// Ports:
//   clk          - single clock, all state on its rising edge
//   reset_n      - asynchronous active-low reset
//   opl3_reg_wr  - register write stream {valid, bank_num, address[7:0], data[7:0]}
//   status       - {IRQ, FT1, FT2, 5'b0}
//   irq_n        - low while IRQ is set
module opl3_timers #(
  parameter int TIMER1_TICK_CYCLES = 1018,
  parameter int TIMER2_TICK_CYCLES = 4073
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] opl3_reg_wr,
  output logic [7:0]  status,
  output logic        irq_n
);

  localparam logic [15:0] T1_LAST = 16'(TIMER1_TICK_CYCLES - 1);
  localparam logic [15:0] T2_LAST = 16'(TIMER2_TICK_CYCLES - 1);

  // Write stream fields
  logic       wr_valid;
  logic       wr_bank;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign wr_valid = opl3_reg_wr[17];
  assign wr_bank  = opl3_reg_wr[16];
  assign wr_addr  = opl3_reg_wr[15:8];
  assign wr_data  = opl3_reg_wr[7:0];

  // Index 0 is timer 1, index 1 is timer 2 throughout.
  logic [1:0][7:0]  preset;
  logic [1:0][7:0]  cnt;
  logic [1:0][15:0] pre;
  logic [1:0]       st;
  logic [1:0]       mt;
  logic [1:0]       ft;
  logic             irq_q;

  logic       wr_acc;
  logic       wr_ctl;
  logic       irq_clr;
  logic [1:0] wr_pre;
  logic [1:0] new_st;
  logic [1:0] new_mt;
  logic [1:0] start;
  logic [1:0] tick;
  logic [1:0] ovf;
  logic [1:0] ft_next;

  // Control bits 2..4 have no function in this block.
  logic unused_ctl_bits;
  assign unused_ctl_bits = ^wr_data[4:2];

  always_comb begin
    wr_acc  = wr_valid && !wr_bank;
    wr_pre  = {wr_acc && (wr_addr == 8'h03), wr_acc && (wr_addr == 8'h02)};
    wr_ctl  = wr_acc && (wr_addr == 8'h04) && !wr_data[7];
    irq_clr = wr_acc && (wr_addr == 8'h04) &&  wr_data[7];
    new_st  = {wr_data[1], wr_data[0]};
    new_mt  = {wr_data[5], wr_data[6]};
    // Only a 0->1 transition of ST reloads; rewriting ST=1 is a no-op.
    start   = wr_ctl ? (new_st & ~st) : 2'b00;
    tick[0] = st[0] && (pre[0] == T1_LAST);
    tick[1] = st[1] && (pre[1] == T2_LAST);
    for (int i = 0; i < 2; i++) begin
      // A start edge overrides any tick landing on the same cycle.
      ovf[i] = tick[i] && !start[i] && (cnt[i] == 8'hFF);
    end
    // IRQ reset beats a coincident overflow; masks only block new sets.
    ft_next = irq_clr ? 2'b00 : (ft | (ovf & ~mt));
  end

  // Control/flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      preset <= '0;
      st     <= '0;
      mt     <= '0;
      ft     <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_pre[i]) preset[i] <= wr_data;
      end
      if (wr_ctl) begin
        st <= new_st;
        mt <= new_mt;
      end
      ft    <= ft_next;
      irq_q <= |ft_next;
    end
  end

  // Counters and prescalers; both hold while the timer is stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      pre <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start[i]) begin
          cnt[i] <= preset[i];
          pre[i] <= '0;
        end else if (st[i]) begin
          if (tick[i]) begin
            pre[i] <= '0;
            cnt[i] <= (cnt[i] == 8'hFF) ? preset[i] : 8'(cnt[i] + 8'd1);
          end else begin
            pre[i] <= 16'(pre[i] + 16'd1);
          end
        end
      end
    end
  end

  assign status = {irq_q, ft[0], ft[1], 5'b00000};
  assign irq_n  = ~irq_q;

endmodule

// File: tb/tb_opl3_timers.sv
// tb/tb_opl3_timers.sv - self-checking bench for opl3_timers
module tb_opl3_timers;

  localparam int T1 = 4;
  localparam int T2 = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] opl3_reg_wr = '0;
  logic [7:0]  status;
  logic        irq_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  opl3_timers #(
    .TIMER1_TICK_CYCLES(T1),
    .TIMER2_TICK_CYCLES(T2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opl3_reg_wr(opl3_reg_wr),
    .status     (status),
    .irq_n      (irq_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic v, input logic b, input logic [7:0] a, input logic [7:0] d);
    opl3_reg_wr = {v, b, a, d};
    step();
    opl3_reg_wr = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] exp_s;
    reset_n = 1'b0;
    #3;
    n_tests++;
    if ({status, irq_n} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset status=%h irq_n=%b want 00/1", status, irq_n);
    end
    do_reset();
    wr(1'b1, 1'b0, 8'h02, 8'hFF);
    wr(1'b1, 1'b0, 8'h03, 8'hFF);
    wr(1'b1, 1'b1, 8'h04, 8'h03);
    wr(1'b0, 1'b0, 8'h04, 8'h03);
    exp_s = 8'h00;
    for (int k = 0; k < 60; k++) begin
      step();
      n_tests++;
      if ({status, irq_n} !== {exp_s, 1'b1}) begin
        n_fail++;
        $display("FAIL ignored_write cyc=%0d status=%h irq_n=%b want 00/1", k, status, irq_n);
      end
    end
  endtask

  task automatic test_first_overflow();
    int s;
    logic [7:0] e;
    do_reset();
    wr(1'b1, 1'b0, 8'h02, 8'hFE);
    wr(1'b1, 1'b0, 8'h04, 8'h01);
    s = cyc;
    for (int k = 1; k <= 9; k++) begin
      step();
      e = (cyc - s >= 8) ? 8'hC0 : 8'h00;
      n_tests++;
      if ({status, irq_n} !== {e, ~e[7]}) begin
        n_fail++;
        $display("FAIL first_overflow k=%0d status=%h irq_n=%b want %h", cyc - s, status, irq_n, e);
      end
    end
  endtask

  task automatic test_mask();
    int s;
    logic [7:0] e;
    do_reset();
    wr(1'b1, 1'b0, 8'h03, 8'hFF);
    wr(1'b1, 1'b0, 8'h04, 8'h22);
    s = cyc;
    for (int k = 0; k < 100; k++) begin
      step();
      n_tests++;
      if ({status, irq_n} !== {8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL masked k=%0d status=%h irq_n=%b want 00/1", cyc - s, status, irq_n);
      end
    end
    wr(1'b1, 1'b0, 8'h04, 8'h02);
    while (cyc < s + 112) begin
      step();
      e = (cyc - s == 112) ? 8'hA0 : 8'h00;
      n_tests++;
      if ({status, irq_n} !== {e, ~e[7]}) begin
        n_fail++;
        $display("FAIL unmask k=%0d status=%h irq_n=%b want %h", cyc - s, status, irq_n, e);
      end
    end
    wr(1'b1, 1'b0, 8'h04, 8'h80);
    while (cyc < s + 128) begin
      step();
      e = (cyc - s == 128) ? 8'hA0 : 8'h00;
      n_tests++;
      if ({status, irq_n} !== {e, ~e[7]}) begin
        n_fail++;
        $display("FAIL period k=%0d status=%h irq_n=%b want %h", cyc - s, status, irq_n, e);
      end
    end
  endtask

  task automatic test_clear_vs_overflow();
    int s;
    logic [7:0] e;
    do_reset();
    wr(1'b1, 1'b0, 8'h04, 8'h01);
    s = cyc;
    while (cyc < s + 1023) step();
    n_tests++;
    if (status !== 8'h00) begin
      n_fail++;
      $display("FAIL pre_overflow status=%h want 00", status);
    end
    wr(1'b1, 1'b0, 8'h04, 8'h80);
    n_tests++;
    if ({status, irq_n} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_wins status=%h irq_n=%b want 00/1", status, irq_n);
    end
    while (cyc < s + 2048) begin
      step();
      e = (cyc - s == 2048) ? 8'hC0 : 8'h00;
      n_tests++;
      if ({status, irq_n} !== {e, ~e[7]}) begin
        n_fail++;
        $display("FAIL after_clear k=%0d status=%h irq_n=%b want %h", cyc - s, status, irq_n, e);
      end
    end
  endtask

  task automatic test_stop_restart();
    int s;
    int r;
    logic [7:0] e;
    do_reset();
    wr(1'b1, 1'b0, 8'h02, 8'hF0);
    wr(1'b1, 1'b0, 8'h04, 8'h01);
    s = cyc;
    while (cyc < s + 22) step();
    wr(1'b1, 1'b0, 8'h04, 8'h00);
    for (int k = 0; k < 200; k++) begin
      step();
      n_tests++;
      if (status !== 8'h00) begin
        n_fail++;
        $display("FAIL stopped k=%0d status=%h want 00", k, status);
      end
    end
    wr(1'b1, 1'b0, 8'h04, 8'h01);
    r = cyc;
    while (cyc < r + 64) begin
      step();
      e = (cyc - r == 64) ? 8'hC0 : 8'h00;
      n_tests++;
      if ({status, irq_n} !== {e, ~e[7]}) begin
        n_fail++;
        $display("FAIL restart k=%0d status=%h irq_n=%b want %h", cyc - r, status, irq_n, e);
      end
    end
  endtask

  task automatic test_async_reset();
    int s;
    do_reset();
    wr(1'b1, 1'b0, 8'h02, 8'hFF);
    wr(1'b1, 1'b0, 8'h04, 8'h01);
    s = cyc;
    while (cyc < s + 5) step();
    n_tests++;
    if (status !== 8'hC0) begin
      n_fail++;
      $display("FAIL pre_reset status=%h want c0", status);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({status, irq_n} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset status=%h irq_n=%b want 00/1", status, irq_n);
    end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      step();
      n_tests++;
      if (status !== 8'h00) begin
        n_fail++;
        $display("FAIL no_restart k=%0d status=%h want 00", k, status);
      end
    end
  endtask

  // Reference: timer n overflows every P_n = (256 - preset) * T_n cycles
  // after the start; a clear at cycle c drops every overflow at or before c.
  task automatic test_random();
    int p1, p2, per1, per2, c, s;
    logic m1, m2, f1, f2;
    logic [7:0] e;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      p1 = $urandom_range(255, 224);
      p2 = $urandom_range(255, 248);
      m1 = 1'($urandom_range(1, 0));
      m2 = 1'($urandom_range(1, 0));
      c  = $urandom_range(250, 1);
      per1 = (256 - p1) * T1;
      per2 = (256 - p2) * T2;
      wr(1'b1, 1'b0, 8'h02, 8'(p1));
      wr(1'b1, 1'b0, 8'h03, 8'(p2));
      wr(1'b1, 1'b0, 8'h04, {1'b0, m1, m2, 5'b00011});
      s = cyc;
      for (int k = 1; k <= 300; k++) begin
        if (k == c) wr(1'b1, 1'b0, 8'h04, 8'h80);
        else step();
        if (k < c) begin
          f1 = !m1 && (k >= per1);
          f2 = !m2 && (k >= per2);
        end else begin
          f1 = !m1 && ((k / per1) > (c / per1));
          f2 = !m2 && ((k / per2) > (c / per2));
        end
        e = {f1 | f2, f1, f2, 5'b00000};
        n_tests++;
        if ({status, irq_n} !== {e, ~e[7]}) begin
          n_fail++;
          $display("FAIL random it=%0d k=%0d p1=%h p2=%h m=%b%b c=%0d status=%h irq_n=%b want %h",
                   it, cyc - s, p1, p2, m1, m2, c, status, irq_n, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_overflow();
    test_mask();
    test_clear_vs_overflow();
    test_stop_restart();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/opl3_timers.md
# opl3_timers

Implements the two OPL3 interval timers and the IRQ/status logic. Sits directly downstream of the register-write stream (`opl3_reg_wr_t`) alongside the register file and consumes only bank-0 writes to addresses 0x02–0x04. Its outputs are the 8-bit status byte returned on host status reads and an active-low IRQ line. It is instantiated only when `INSTANTIATE_TIMERS` = 1.

## Interface
- `TIMER1_TICK_CYCLES`, default 1018: clk cycles per timer-1 tick, equal to round(`CLK_FREQ` × `TIMER1_TICK_INTERVAL`). Range 2..65535.
- `TIMER2_TICK_CYCLES`, default 4073: clk cycles per timer-2 tick, equal to round(`CLK_FREQ` × `TIMER2_TICK_INTERVAL`). Range 2..65535.
- `clk`, in, 1: the single clock. All state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `opl3_reg_wr`, in, `opl3_reg_wr_t` (18 bits: valid, bank_num, address[7:0], data[7:0]): register write stream, one write per cycle at most.
- `status`, out, 8: {IRQ, FT1, FT2, 5'b0}.
- `irq_n`, out, 1: low while IRQ = 1.

## Operation
- Accepted write: `valid` = 1 and `bank_num` = 0. All other writes are ignored.
  - Address 0x02 loads `preset1` ← data.
  - Address 0x03 loads `preset2` ← data.
  - Address 0x04 with data[7] = 1 is an IRQ reset: it clears FT1 and FT2. All other bits of that write are ignored, and ST/MT are unchanged.
  - Address 0x04 with data[7] = 0 loads ST1 ← d[0], ST2 ← d[1], MT2 ← d[5], MT1 ← d[6].
- Per timer n ∈ {1,2}, the state is 8-bit `cnt`n, 16-bit `pre`n, and `run`n (= STn).
- Start edge (STn 0→1): `cnt`n ← `preset`n and `pre`n ← 0. Writing STn = 1 while it is already 1 does not reload anything.
- Stop (STn 1→0): `cnt`n and `pre`n hold and no ticks occur.
- While running, `pre`n counts 0..`TIMERn_TICK_CYCLES`−1 and wraps. A tick fires on the cycle where `pre`n == `TIMERn_TICK_CYCLES`−1.
- On a tick with `cnt`n < 0xFF: `cnt`n ← `cnt`n + 1.
- On a tick with `cnt`n == 0xFF (overflow): `cnt`n ← `preset`n, and FTn ← 1 unless MTn = 1.
- A preset write while running affects only the next reload. The current count is unchanged.
- Masking (MTn = 1) blocks new FTn sets only. An FTn that is already set stays set until an IRQ reset.
- IRQ = FT1 | FT2, and `irq_n` = ~IRQ.
- Simultaneous events:
  - IRQ reset and overflow on the same cycle: the clear wins and FTn = 0.
  - Start edge and a stale tick on the same cycle: the start wins (load preset, clear prescaler).
  - Both timers overflowing on the same cycle set both flags.

## Timing
- Reset values: `status` = 0x00, `irq_n` = 1. All of ST, MT, FT, `preset`, `cnt` and `pre` are 0.
- A write sampled at edge N takes effect at N: updated state is visible after N.
- Flag visibility:
  - FTn, `status` and `irq_n` are all registered.
  - An overflow tick on the cycle ending at edge E gives flag visibility after E.
  - After a start edge at edge S, the first tick is at edge S + `TIMERn_TICK_CYCLES`.
  - The overflow (FTn set) is at edge S + (256 − preset) × `TIMERn_TICK_CYCLES`.
  - Subsequent overflows repeat every (256 − preset) × `TIMERn_TICK_CYCLES` cycles.
- IRQ reset written at edge N: `status` = 0x00 and `irq_n` = 1 after N.
- Asserting `reset_n` mid-count: all state clears immediately (asynchronously). After release, the timers stay stopped until STn is written again.

## Test plan
1. Reset check, then a bank-1 write to 0x04 = 0x03: `status` stays 0x00, `irq_n` stays 1, and no ticks occur.
2. With `TIMER1_TICK_CYCLES` = 4: write 0x02 = 0xFE, then 0x04 = 0x01 at edge S. Required: `status` = 0xC0 and `irq_n` = 0 exactly after S+8, not before.
3. With `TIMER2_TICK_CYCLES` = 16: write 0x03 = 0xFF, then 0x04 = 0x22 (ST2 with MT2 set). Required: no flag over 100 cycles. Then write 0x04 = 0x02 (mask cleared, no start edge). Required: FT2 is set at the next overflow (`status` = 0xA0), with 16-cycle overflow periodicity.
4. With timer 1 running at preset 0x00 and `TIMER1_TICK_CYCLES` = 4: write 0x04 = 0x80 on the exact overflow cycle (edge S+1024). Required: FT1 = 0, and the next overflow at S+2048 sets FT1.
5. Start timer 1 (preset 0xF0), stop it after 5 ticks, wait 200 cycles, then restart. Required: the counter reloads to 0xF0 and the overflow is 16 ticks after the restart.
6. Assert `reset_n` low mid-count with FT1 = 1. Required: `status` = 0x00 and `irq_n` = 1 within the same cycle. After release, there is no flag without a new start.
